// File: rtl/uart_tx_apb_if.sv
// APB3 slave-side signal bundle for the UART transmitter.
// The master modport is used by whoever drives the bus (CPU bridge or bench).
// The slave modport is used by uart_tx_apb.
interface uart_tx_apb_if;
  logic [31:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

// File: rtl/uart_tx_apb.sv
// APB-slave UART transmitter (8N1 by default).
//
// A one-entry holding register is written over APB.
// A bit-level FSM moves the byte into a shift register and serialises it on
// Tx, LSB first, timed by the shared oversampled baud tick.
//
// Handshake: an APB transfer is in its access phase when PSEL & PENABLE. It
// completes on the rising PCLK edge where PREADY is high in that phase.
// PRDATA and PSLVERR are only meaningful in the completing cycle.
// A TXDATA write is the only access that can see PREADY low. It is held
// off while the holding register is full, and released in the same cycle
// the FSM drains the register.
module uart_tx_apb #(
  parameter int          DATA_BITS   = 8,
  parameter int          OVERSAMPLE  = 16,
  parameter logic [31:0] ADDR_TXDATA = 32'h0001,
  parameter logic [31:0] ADDR_STATUS = 32'h0003
) (
  input  logic         PCLK,
  input  logic         PRESET,
  input  logic         tick,
  uart_tx_apb_if.slave apb,
  output logic         Tx,
  output logic         TX_Done,
  output logic [1:0]   state_dbg
);

  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t                 state;
  logic [CW-1:0]          tick_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shift_q;
  logic [DATA_BITS-1:0]   hold_data;
  logic                   hold_full;
  logic                   tx_q;
  logic                   done_q;

  logic access;
  logic hit_tx;
  logic hit_st;
  logic wr_tx;
  logic rd_st;
  logic bad_acc;
  logic bit_end;
  logic load;
  logic wr_fire;
  logic busy;

  // PWDATA bits above the payload width carry no meaning for this block.
  logic unused_pwdata;
  assign unused_pwdata = ^apb.PWDATA[31:DATA_BITS];

  // Bus decode and holding-register control, all combinational.
  always_comb begin
    access  = apb.PSEL & apb.PENABLE;
    hit_tx  = (apb.PADDR == ADDR_TXDATA);
    hit_st  = (apb.PADDR == ADDR_STATUS);
    wr_tx   = access & apb.PWRITE & hit_tx;
    rd_st   = access & ~apb.PWRITE & hit_st;
    bad_acc = access & ((~hit_tx & ~hit_st) | (~apb.PWRITE & hit_tx));
    busy    = (state != S_IDLE);
    bit_end = tick & (tick_cnt == CNT_MAX);
    // The FSM drains the holding register from IDLE, or straight out of the
    // stop bit for back-to-back frames.
    load    = hold_full & ((state == S_IDLE) | ((state == S_STOP) & bit_end));
    // A write to a full register lands in the cycle the FSM drains it.
    wr_fire = wr_tx & (~hold_full | load);
  end

  // APB response outputs; held at their reset values while PRESET is high.
  always_comb begin
    apb.PREADY  = 1'b1;
    apb.PRDATA  = 32'h0;
    apb.PSLVERR = 1'b0;
    if (!PRESET) begin
      apb.PREADY  = ~(wr_tx & hold_full & ~load);
      apb.PRDATA  = rd_st ? {30'b0, hold_full, busy} : 32'h0;
      apb.PSLVERR = bad_acc;
    end
  end

  // Holding register: filled by APB writes, emptied when the FSM loads it.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else if (wr_fire) begin
      hold_data <= apb.PWDATA[DATA_BITS-1:0];
      hold_full <= 1'b1;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  // Frame FSM; Tx and TX_Done are registered so the line never glitches.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          // The start bit begins on this edge, unaligned to tick.
          if (hold_full) begin
            shift_q  <= hold_data;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            tx_q     <= 1'b0;
            state    <= S_START;
          end
        end
        S_START: begin
          if (tick) begin
            if (tick_cnt == CNT_MAX) begin
              tick_cnt <= '0;
              tx_q     <= shift_q[0];
              state    <= S_DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            if (tick_cnt == CNT_MAX) begin
              tick_cnt <= '0;
              if (bit_cnt == BIT_MAX) begin
                tx_q  <= 1'b1;
                state <= S_STOP;
              end else begin
                shift_q <= shift_q >> 1;
                tx_q    <= shift_q[1];
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        S_STOP: begin
          if (tick) begin
            if (tick_cnt == CNT_MAX) begin
              tick_cnt <= '0;
              done_q   <= 1'b1;
              if (hold_full) begin
                // Back-to-back frame: no idle gap after the stop bit.
                shift_q <= hold_data;
                bit_cnt <= '0;
                tx_q    <= 1'b0;
                state   <= S_START;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

  assign Tx        = tx_q;
  assign TX_Done   = done_q;
  assign state_dbg = state;

endmodule

// File: doc/uart_tx_apb.md
Name: uart_tx_apb

Overview:
APB-slave UART transmitter, 8N1 by default; the transmit-side counterpart of UartRx.
- CPU writes a byte over APB into a one-entry holding register.
- A bit-level FSM serialises that byte onto Tx, timed by the same oversampled `tick` that BaudRate supplies to UartRx.
- Status is readable over APB.
- Sits beside UartRx on the same PCLK/APB bus, sharing the BaudRate instance.

Parameters:
- DATA_BITS, 8, payload bits per frame (LSB first); legal range 5..8.
- OVERSAMPLE, 16, tick pulses per bit period.
- ADDR_TXDATA, 32'h0001, APB write address of the holding register.
- ADDR_STATUS, 32'h0003, APB read address of the status register.

Ports:
- PCLK  in  1  system/APB clock, rising edge.
- PRESET  in  1  synchronous reset, active-high.
- tick  in  1  one-PCLK-wide pulse at OVERSAMPLE × baud, from BaudRate.
- PADDR  in  32  APB address.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable (access phase).
- PWRITE  in  1  1 = write, 0 = read.
- PWDATA  in  32  write data; bits [DATA_BITS-1:0] used.
- PREADY  out  1  APB ready; low inserts wait states.
- PRDATA  out  32  read data.
- PSLVERR  out  1  APB error.
- Tx  out  1  serial line; idles high.
- TX_Done  out  1  one-PCLK pulse at end of stop bit.

Behaviour:
- Reset: PRESET sampled high at a PCLK edge forces these values on that edge, regardless of frame state:
  - Tx=1, TX_Done=0, PREADY=1, PRDATA=0, PSLVERR=0.
  - Holding register empty, FSM=IDLE, tick counter=0, bit counter=0.
  - A frame in progress is abandoned; Tx returns high with no glitch to 0.
- APB access phase is PSEL & PENABLE.
- Write to ADDR_TXDATA:
  - Holding empty: PREADY=1 that cycle; PWDATA[DATA_BITS-1:0] latched; holding becomes full on the same edge.
  - Holding full: PREADY=0 (wait states) until the FSM empties the holding register; PREADY rises that same cycle and the write completes.
- Read of ADDR_STATUS: PREADY=1, zero wait states.
  - PRDATA = {30'b0, hold_full, busy}, where busy = FSM != IDLE.
  - PRDATA is combinational during the access phase and 0 otherwise.
- Any other address, or a read of ADDR_TXDATA: PREADY=1, PSLVERR=1 for that access cycle, no state change.
- Setup phase (PSEL & !PENABLE) has no effect.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: Tx=1. If holding is full, the next edge moves the byte to the shift register, clears holding, resets both counters and enters START. The start bit begins on that edge, not aligned to tick.
  - START: Tx=0. Tick counter increments on each tick. At OVERSAMPLE-1 with tick, counter→0 and go to DATA.
  - DATA: Tx = shift[0]. At end of each bit period, shift right and increment the bit counter. After bit DATA_BITS-1, go to STOP.
  - STOP: Tx=1 for OVERSAMPLE ticks. At the end, TX_Done=1 for exactly one cycle.
    - Holding full → go straight to START; back-to-back frames have no idle gap.
    - Otherwise → go to IDLE.
- A frame lasts exactly (DATA_BITS+2)×OVERSAMPLE tick pulses after the start edge.
- Holding register refills while a frame is in flight, so a second write never stalls and a third write stalls until the second byte is loaded.
- A write completing in the same cycle the FSM loads the holding register:
  - Cannot occur as a full→full overwrite: PREADY is low whenever holding is full.
  - A write to an empty holding register in the same cycle as the IDLE load condition is impossible by construction.
- tick is ignored in IDLE.
- PSLVERR asserts only during the error access cycle.

Test Plan:
1. Reset: PRESET=1 for 2 cycles, then 0 → Tx=1, PREADY=1, TX_Done=0, STATUS read = 0x0.
2. Single byte: write 0x55 to ADDR_TXDATA (tick every 4 PCLK) → Tx sequence 0,1,0,1,0,1,0,1,0,1, each level held 16 ticks (64 PCLK). TX_Done pulses once, 640 PCLK after the load. STATUS during frame = 0x1, after = 0x0.
3. Back-to-back: write 0xA3 then immediately 0x0F → second write completes with no wait states; STATUS=0x3. Frames are contiguous with no high gap beyond the 16-tick stop bit. Bits are LSB-first: 1,1,0,0,0,1,0,1 then 1,1,1,1,0,0,0,0. TX_Done pulses twice.
4. Stall: three consecutive writes 0x11, 0x22, 0x33 → third write's PREADY stays low until 0x22 is loaded at the end of the 0x11 stop bit. All three bytes appear on Tx in order.
5. Reset mid-frame: assert PRESET during DATA bit 3 of 0xF0 → Tx=1 the next edge, STATUS=0x0, no TX_Done. A subsequent write of 0x81 transmits cleanly.
6. Errors: read ADDR_TXDATA and write 32'h0007 → PREADY=1, PSLVERR=1 for one cycle each, Tx unchanged, STATUS unchanged.
